dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/rr_arb2.sv | 18 +
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DMEM_DEPTH = 128;
    localparam int unsigned DMEM_IDX_W = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; on contention the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory: grant, access, respond,
// one transaction every three cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = DMEM_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] addr0,
    input  logic [DATA_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [DATA_W-1:0] IDX_MASK = {DATA_W{1'b1}} >> (DATA_W - IDX_W);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_we;
    logic              r_owner;
    logic              r_last;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              r_err;
    logic [1:0]        w_pick;
    logic [1:0]        w_grant;
    logic              w_oor;

    rr_arb2 u_rr_arb2 (
        .req  ({req1, req0}),
        .last (r_last),
        .gnt  (w_pick)
    );

    // Captured address is kept unmasked so range errors can be detected later.
    assign w_oor = |(r_addr & ~IDX_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_grant = '0;
        mem_we  = 1'b0;
        busy    = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (!rst) w_grant = w_pick;
                if (req0 | req1) w_next = ACCESS;
            end
            ACCESS: begin
                mem_we = r_we & ~w_oor;
                w_next = RESP;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err     <= 1'b0;
            if (|w_grant) begin
                r_addr  <= w_grant[1] ? addr1  : addr0;
                r_wdata <= w_grant[1] ? wdata1 : wdata0;
                r_we    <= w_grant[1] ? we1    : we0;
                r_owner <= w_grant[1];
                r_last  <= w_grant[1];
            end
            if (r_state == RESP) begin
                if (r_owner) begin
                    r_rdata1  <= w_oor ? '0 : mem_rdata;
                    r_rvalid1 <= 1'b1;
                end else begin
                    r_rdata0  <= w_oor ? '0 : mem_rdata;
                    r_rvalid0 <= 1'b1;
                end
                r_err <= w_oor;
            end
        end
    end

    assign gnt0      = w_grant[0];
    assign gnt1      = w_grant[1];
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign err       = r_err;
    assign mem_addr  = r_addr & IDX_MASK;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural memory and response scoreboard.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, err, mem_we, busy;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] memarr [128] = '{default: 32'h0};
    logic [31:0] shadow [128];
    logic [31:0] exp_rdata [2];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    dmem_arbiter #(.DATA_W(32), .IDX_W(7)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory: data read in ACCESS is presented during RESP.
    always @(posedge clk) begin
        if (mem_we) memarr[mem_addr[6:0]] <= mem_wdata;
        mem_rdata <= memarr[mem_addr[6:0]];
    end

    task automatic expect_txn(input int id, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata);
        exp_t e;
        logic oor;
        oor    = (addr >= 32'd128);
        e.id   = id;
        e.err  = oor;
        e.data = oor ? 32'h0 : shadow[addr[6:0]];
        if (we && !oor) shadow[addr[6:0]] = wdata;
        exp_q.push_back(e);
    endtask

    // Response monitor: protocol invariants and scoreboard pops.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            int   id;
            n_checks++;
            if (gnt0 && gnt1) begin
                n_fail++; $display("FAIL gnt_onehot: gnt0=%b gnt1=%b, required at most one", gnt0, gnt1);
            end
            n_checks++;
            if ((gnt0 || gnt1) && busy) begin
                n_fail++; $display("FAIL gnt_when_busy: gnt0=%b gnt1=%b busy=%b, required no grant while busy", gnt0, gnt1, busy);
            end
            if (rvalid0 || rvalid1) begin
                n_checks++;
                if (rvalid0 && rvalid1) begin
                    n_fail++; $display("FAIL rvalid_onehot: both rvalid high, required one");
                end else if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL unexpected_rvalid: rvalid0=%b rvalid1=%b, required none", rvalid0, rvalid1);
                end else begin
                    e  = exp_q.pop_front();
                    id = rvalid1 ? 1 : 0;
                    if (id !== e.id) begin
                        n_fail++; $display("FAIL resp_owner: got %0d, required %0d", id, e.id);
                    end
                    n_checks++;
                    if ((id ? rdata1 : rdata0) !== e.data) begin
                        n_fail++; $display("FAIL resp_data%0d: got %h, required %h", id, id ? rdata1 : rdata0, e.data);
                    end
                    n_checks++;
                    if (err !== e.err) begin
                        n_fail++; $display("FAIL resp_err: got %b, required %b", err, e.err);
                    end
                    n_checks++;
                    if ((id ? rdata0 : rdata1) !== exp_rdata[1-id]) begin
                        n_fail++; $display("FAIL other_rdata: got %h, required %h", id ? rdata0 : rdata1, exp_rdata[1-id]);
                    end
                    exp_rdata[id] = e.data;
                end
            end else begin
                n_checks++;
                if (err !== 1'b0) begin
                    n_fail++; $display("FAIL err_idle: got %b, required 0", err);
                end
            end
        end
    end

    task automatic run_single(input int id, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input string tag);
        int   t;
        logic oor;
        oor = (addr >= 32'd128);
        @(posedge clk); #1;
        if (id == 0) begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wdata; end
        else         begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wdata; end
        expect_txn(id, we, addr, wdata);
        t = 0;
        @(negedge clk);
        while (!(id ? gnt1 : gnt0) && t < 20) begin @(negedge clk); t++; end
        n_checks++;
        if (t >= 20) begin n_fail++; $display("FAIL %s_gnt: no grant within 20 cycles", tag); end
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        @(negedge clk);
        n_checks++;
        if (mem_we !== (we && !oor) || mem_addr !== (addr & 32'h7f) || mem_wdata !== wdata || busy !== 1'b1) begin
            n_fail++; $display("FAIL %s_access: we=%b addr=%h wdata=%h busy=%b, required we=%b addr=%h wdata=%h busy=1",
                               tag, mem_we, mem_addr, mem_wdata, busy, we && !oor, addr & 32'h7f, wdata);
        end
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b0 || busy !== 1'b1 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || mem_addr !== (addr & 32'h7f)) begin
            n_fail++; $display("FAIL %s_resp: we=%b busy=%b rv=%b%b addr=%h, required we=0 busy=1 rv=00 addr=%h",
                               tag, mem_we, busy, rvalid1, rvalid0, mem_addr, addr & 32'h7f);
        end
        @(negedge clk);
        n_checks++;
        if ((id ? rvalid1 : rvalid0) !== 1'b1 || busy !== 1'b0 || err !== oor) begin
            n_fail++; $display("FAIL %s_done: rvalid=%b busy=%b err=%b, required rvalid=1 busy=0 err=%b",
                               tag, id ? rvalid1 : rvalid0, busy, err, oor);
        end
    endtask

    task automatic test_reset();
        req0 = 1; we0 = 1; addr0 = 32'h5; wdata0 = 32'h1234;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, err, mem_we, busy} !== 7'b0 ||
            rdata0 !== 32'h0 || rdata1 !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs: gnt=%b%b rv=%b%b err=%b we=%b busy=%b addr=%h, required all 0",
                               gnt1, gnt0, rvalid1, rvalid0, err, mem_we, busy, mem_addr);
        end
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_write();
        run_single(0, 1'b1, 32'h05, 32'hDEADBEEF, "write0");
    endtask

    task automatic test_read();
        run_single(1, 1'b0, 32'h05, 32'h0, "read1");
        @(negedge clk);
        n_checks++;
        if (rdata1 !== 32'hDEADBEEF || rdata0 !== exp_rdata[0]) begin
            n_fail++; $display("FAIL read1_hold: rdata1=%h rdata0=%h, required %h and %h", rdata1, rdata0, 32'hDEADBEEF, exp_rdata[0]);
        end
    endtask

    task automatic test_back_to_back();
        int ng, t, last_c;
        @(posedge clk); #1;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h05; addr1 = 32'h10;
        for (int k = 0; k < 6; k++) expect_txn(k % 2, 1'b0, (k % 2) ? addr1 : addr0, 32'h0);
        ng = 0; t = 0; last_c = 0;
        while (ng < 6 && t < 60) begin
            @(negedge clk); t++;
            if (gnt0 || gnt1) begin
                n_checks++;
                if (gnt1 !== ((ng % 2) == 1)) begin
                    n_fail++; $display("FAIL rr_order: grant %0d went to %0d, required %0d", ng, gnt1 ? 1 : 0, ng % 2);
                end
                if (ng > 0) begin
                    n_checks++;
                    if (cyc - last_c != 3) begin
                        n_fail++; $display("FAIL rr_spacing: %0d cycles between grants, required 3", cyc - last_c);
                    end
                end
                last_c = cyc;
                ng++;
                if (ng == 6) begin @(posedge clk); #1; req0 = 0; req1 = 0; end
            end
        end
        n_checks++;
        if (ng != 6) begin n_fail++; $display("FAIL rr_count: %0d grants, required 6", ng); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_out_of_range();
        run_single(0, 1'b0, 32'h00000080, 32'h0, "oor_read");
        run_single(0, 1'b1, 32'h00000105, 32'hCAFEF00D, "oor_write");
        run_single(1, 1'b0, 32'h05, 32'h0, "after_oor");
    endtask

    task automatic test_reset_mid();
        int t;
        @(posedge clk); #1;
        req0 = 1; we0 = 1; addr0 = 32'h07; wdata0 = 32'h55AA55AA;
        @(negedge clk);
        n_checks++;
        if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt: gnt0=%b, required 1", gnt0); end
        @(posedge clk); #1;
        req0 = 0;
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_access: mem_we=%b, required 1", mem_we); end
        #1 rst = 1;
        #1;
        n_checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_abort: mem_we=%b busy=%b rv=%b%b, required all 0", mem_we, busy, rvalid1, rvalid0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
        req0 = 1; we0 = 0; addr0 = 32'h07;
        req1 = 1; we1 = 0; addr1 = 32'h05;
        expect_txn(0, 1'b0, 32'h07, 32'h0);
        expect_txn(1, 1'b0, 32'h05, 32'h0);
        @(negedge clk);
        n_checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_first: gnt0=%b gnt1=%b, required gnt0=1 gnt1=0", gnt0, gnt1);
        end
        @(posedge clk); #1;
        req0 = 0;
        t = 0;
        @(negedge clk);
        while (!gnt1 && t < 20) begin @(negedge clk); t++; end
        n_checks++;
        if (t >= 20) begin n_fail++; $display("FAIL rstmid_gnt1: no grant within 20 cycles"); end
        @(posedge clk); #1;
        req1 = 0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) shadow[i] = 32'h0;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
